// File: rtl/mmio_uart_tx.sv
//-----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter sitting on the core's store path. The core
// stores bytes into a small TX FIFO; a bit-serial engine drains the FIFO and
// sends each byte as an 8N1 frame on tx_o, LSB first. Status flags and the
// baud divisor (clk cycles per bit) can be read and written over the same bus.
//
// Register map (addr_i):
//   0 DATA    write: push wdata_i[7:0]        read: 0
//   1 STATUS  write: wdata_i[3]=1 clears overflow
//             read : {28'b0, overflow, fifo_empty, fifo_full, busy}
//   2 BAUD    write: wdata_i[15:0], 0 treated as 1, used from next bit start
//             read : {16'b0, baud}
//   3 reserved (reads 0, writes ignored)
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      asynchronous active-low reset
//   sel_i    address decode hit for this peripheral
//   we_i     store strobe, acts only when sel_i=1
//   addr_i   register select
//   wdata_i  store data
//   rdata_o  combinational read data for addr_i, 0 when sel_i=0
//   tx_o     registered serial line, idle high
//   busy_o   frame in progress or FIFO non-empty
//
// Configuration macro:
//   UART_TX_PARITY_EN  adds an even-parity bit after data bit 7 (11-bit frame).
//                      Undefined (default): plain 10-bit 8N1 frame.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mmio_uart_tx #(
   parameter int WIDTH       = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int DEFAULT_DIV = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel_i,
   input  logic             we_i,
   input  logic [1:0]       addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             tx_o,
   output logic             busy_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_BAUD   = 2'd2;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;
`endif

   // Serialiser state
   state_t           state_q,   state_d;
   logic [7:0]       data_q,    data_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [15:0]      timer_q,   timer_d;
   logic             tx_q,      tx_d;

   // Register file
   logic [15:0]      baud_q,    baud_d;
   logic             ovf_q,     ovf_d;

   // FIFO bookkeeping
   logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [7:0]       mem [FIFO_DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic bit_end;
   logic pop;
   logic push;
   logic wr_data;
   logic wr_status;
   logic wr_baud;
   logic [2:0] next_idx;

   // Upper store-data bits have no meaning in this block.
   logic unused_wdata;
   assign unused_wdata = ^wdata_i[WIDTH-1:16];

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign bit_end    = (timer_q == 16'd0);
   assign next_idx   = bit_idx_q + 3'd1;

   assign wr_data    = sel_i & we_i & (addr_i == ADDR_DATA);
   assign wr_status  = sel_i & we_i & (addr_i == ADDR_STATUS);
   assign wr_baud    = sel_i & we_i & (addr_i == ADDR_BAUD);

   //--------------------------------------------------------------------------
   // Serialiser next-state. Every bit start reloads the down-counter from the
   // current divisor, so a BAUD write only shows up at the next bit boundary.
   //--------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d   = state_q;
      data_d    = data_q;
      bit_idx_d = bit_idx_q;
      timer_d   = timer_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      if (state_q != ST_IDLE && !bit_end) begin
         timer_d = timer_q - 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               data_d    = mem[rd_ptr_q];
               bit_idx_d = 3'd0;
               tx_d      = 1'b0;
               timer_d   = baud_q - 16'd1;
               state_d   = ST_START;
            end
         end

         ST_START: begin
            if (bit_end) begin
               bit_idx_d = 3'd0;
               tx_d      = data_q[0];
               timer_d   = baud_q - 16'd1;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               timer_d = baud_q - 16'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^data_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = next_idx;
                  tx_d      = data_q[next_idx];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               timer_d = baud_q - 16'd1;
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (bit_end) begin
               bit_idx_d = 3'd0;
               if (!fifo_empty) begin
                  // Back-to-back frames: the next start bit follows the stop
                  // bit with no idle cycle.
                  pop     = 1'b1;
                  data_d  = mem[rd_ptr_q];
                  tx_d    = 1'b0;
                  timer_d = baud_q - 16'd1;
                  state_d = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  timer_d = 16'd0;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            timer_d = 16'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // FIFO pointers and bus-visible registers. A push into a full FIFO still
   // succeeds when the serialiser pops in the same cycle.
   //--------------------------------------------------------------------------
   always_comb begin
      push     = wr_data & (!fifo_full | pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

      ovf_d = ovf_q;
      if (wr_data && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end else if (wr_status && wdata_i[3]) begin
         ovf_d = 1'b0;
      end

      baud_d = baud_q;
      if (wr_baud) begin
         baud_d = (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q   <= ST_IDLE;
         data_q    <= 8'd0;
         bit_idx_q <= 3'd0;
         timer_q   <= 16'd0;
         tx_q      <= 1'b1;
         baud_q    <= 16'(DEFAULT_DIV);
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bit_idx_q <= bit_idx_d;
         timer_q   <= timer_d;
         tx_q      <= tx_d;
         baud_q    <= baud_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // NOTE: FIFO storage is not reset; the count and pointers decide which
   // entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata_i[7:0];
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign tx_o   = tx_q;
   assign busy_o = (state_q != ST_IDLE) | ~fifo_empty;

   always_comb begin
      rdata_o = '0;
      if (sel_i) begin
         case (addr_i)
            ADDR_STATUS: rdata_o = WIDTH'({ovf_q, fifo_empty, fifo_full, busy_o});
            ADDR_BAUD:   rdata_o = WIDTH'(baud_q);
            default:     rdata_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
//-----------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Self-checking bench for mmio_uart_tx. A behavioural model keeps the FIFO as
// a queue and the line as a queue of per-cycle levels of the frame in flight;
// every falling clock edge compares tx_o, busy_o and rdata_o against it.
// Directed sequences pin the model with literal expectations, then a random
// phase exercises bus traffic. Build with +define+UART_TX_PARITY_EN to cover
// the parity variant.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mmio_uart_tx;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             sel   = 1'b0;
   logic             we    = 1'b0;
   logic [1:0]       addr  = 2'd0;
   logic [WIDTH-1:0] wdata = '0;
   logic [WIDTH-1:0] rdata;
   logic             tx;
   logic             busy;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .WIDTH       (WIDTH),
      .FIFO_DEPTH  (DEPTH),
      .DEFAULT_DIV (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sel_i   (sel),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .tx_o    (tx),
      .busy_o  (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   //--------------------------------------------------------------------------
   // Behavioural model
   //--------------------------------------------------------------------------
   bit         line_q[$];   // line level for the current and following cycles
   logic [7:0] fifo_m[$];
   logic       ovf_m  = 1'b0;
   logic [15:0] baud_m = 16'd16;
   logic [7:0] byte_m;

   function automatic void load_frame(input logic [7:0] b);
      bit fb[$];
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      fb.push_back(^b);
`endif
      fb.push_back(1'b1);
      for (int i = 0; i < fb.size(); i++)
         for (int j = 0; j < int'(baud_m); j++) line_q.push_back(fb[i]);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_q.delete();
         fifo_m.delete();
         ovf_m  = 1'b0;
         baud_m = 16'd16;
      end else begin
         if (line_q.size() != 0) void'(line_q.pop_front());
         if (line_q.size() == 0 && fifo_m.size() != 0) begin
            byte_m = fifo_m.pop_front();
            load_frame(byte_m);
         end
         if (sel && we) begin
            case (addr)
               2'd0: if (fifo_m.size() < DEPTH) fifo_m.push_back(wdata[7:0]);
                     else ovf_m = 1'b1;
               2'd1: if (wdata[3]) ovf_m = 1'b0;
               2'd2: baud_m = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
               default: ;
            endcase
         end
      end
   end

   function automatic logic exp_tx();
      return (line_q.size() != 0) ? line_q[0] : 1'b1;
   endfunction

   function automatic logic exp_busy();
      return (line_q.size() != 0) || (fifo_m.size() != 0);
   endfunction

   function automatic logic [31:0] exp_rdata();
      if (!sel) return 32'd0;
      case (addr)
         2'd1: return {28'd0, ovf_m, fifo_m.size() == 0, fifo_m.size() == DEPTH, exp_busy()};
         2'd2: return {16'd0, baud_m};
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      check("model_tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("model_busy", {31'd0, busy}, {31'd0, exp_busy()});
      check("model_rdata", rdata, exp_rdata());
   end

   //--------------------------------------------------------------------------
   // Bus helpers (called and returning at posedge + 1)
   //--------------------------------------------------------------------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      check(name, rdata, exp);
      @(posedge clk); #1;
      sel = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   //--------------------------------------------------------------------------
   // Stimulus
   //--------------------------------------------------------------------------
   initial begin
      logic [10:0] f_a5;
      logic [10:0] f_07;
      int          fr_len;
      int          r;

`ifdef UART_TX_PARITY_EN
      f_a5   = 11'b1_0_1010_0101_0;   // stop, parity(0), 0xA5, start
      fr_len = 11;
`else
      f_a5   = 11'b0_1_1010_0101_0;   // bit 10 unused, stop, 0xA5, start
      fr_len = 10;
`endif
      f_07 = 11'b1_1_0000_0111_0;     // stop, parity(1), 0x07, start

      #1 rst = 1'b0;
      #22 rst = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      bus_read(2'd1, 32'h4, "reset_status");
      bus_read(2'd2, 32'd16, "reset_baud");
      bus_read(2'd0, 32'd0, "reset_data_read");

      // BAUD=4, single 0xA5 frame
      bus_write(2'd2, 32'd4);
      bus_read(2'd2, 32'd4, "baud4_read");
      bus_write(2'd0, 32'hA5);
      @(negedge clk);
      check("a5_latency_tx", {31'd0, tx}, 32'd1);
      for (int i = 0; i < fr_len * 4; i++) begin
         @(negedge clk);
         check("a5_frame_bit", {31'd0, tx}, {31'd0, f_a5[i / 4]});
      end
      @(negedge clk);
      check("a5_busy_after", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      // BAUD=2, five back-to-back writes: first pops at once, no overflow
      bus_write(2'd2, 32'd2);
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'(8'h30 + i));
      bus_read(2'd1, 32'h3, "burst5_status_full");
      wait_idle(300, "burst5_drain");
      bus_read(2'd1, 32'h4, "burst5_status_idle");

      // BAUD=16, six writes: last one dropped, overflow sticky until cleared
      bus_write(2'd2, 32'd16);
      for (int i = 0; i < 6; i++) bus_write(2'd0, 32'(8'h51 + 3 * i));
      bus_read(2'd1, 32'hB, "ovf_status_full");
      repeat (200) @(posedge clk);
      #1;
      bus_read(2'd1, 32'h9, "ovf_status_busy");
      bus_write(2'd1, 32'h8);
      bus_read(2'd1, 32'h1, "ovf_cleared");
      wait_idle(1200, "ovf_drain");

      // Reset asserted in the middle of data bit 3
      bus_write(2'd2, 32'd4);
      bus_write(2'd0, 32'hA5);
      repeat (18) @(posedge clk);
      #2;
      check("pre_reset_tx", {31'd0, tx}, 32'd0);
      rst = 1'b0;
      #1;
      check("async_reset_tx", {31'd0, tx}, 32'd1);
      check("async_reset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      bus_read(2'd1, 32'h4, "post_reset_status");
      bus_read(2'd2, 32'd16, "post_reset_baud");
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check("no_residual_tx", {31'd0, tx}, 32'd1);
      end
      @(posedge clk); #1;

`ifdef UART_TX_PARITY_EN
      // Parity frame, BAUD=1, DATA=0x07
      bus_write(2'd2, 32'd0);          // 0 behaves as 1
      bus_read(2'd2, 32'd1, "baud0_read");
      bus_write(2'd0, 32'h07);
      @(negedge clk);
      check("par_latency_tx", {31'd0, tx}, 32'd1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check("par_frame_bit", {31'd0, tx}, {31'd0, f_07[i]});
      end
      @(posedge clk); #1;
      wait_idle(50, "par_drain");
`endif

      // Random bus traffic against the model
      bus_write(2'd2, 32'd2);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         r = $urandom_range(0, 99);
         sel = 1'b0; we = 1'b0; addr = 2'($urandom_range(0, 3)); wdata = $urandom;
         if (r < 7) begin
            sel = 1'b1; we = 1'b1; addr = 2'd0;
         end else if (r < 11) begin
            sel = 1'b1; we = 1'b1; addr = 2'd1;
         end else if (r < 20) begin
            sel = 1'b1;
         end else if (r < 23) begin
            if (line_q.size() == 0 && fifo_m.size() == 0) begin
               sel = 1'b1; we = 1'b1; addr = 2'd2;
               wdata = 32'($urandom_range(0, 3)) | 32'hABCD_0000;
            end
         end else if (r < 26) begin
            we = 1'b1;                   // store without select: ignored
         end else if (r < 28) begin
            sel = 1'b1; we = 1'b1; addr = 2'd3;
         end
         @(posedge clk); #1;
         sel = 1'b0; we = 1'b0;
      end
      wait_idle(2000, "random_drain");
      bus_read(2'd1, {28'd0, ovf_m, 3'b100}, "random_final_status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
